// File: rtl/id_inst_buffer.sv
// id_inst_buffer: DEPTH-entry circular instruction queue between the I-cache
// return path and the ID decoder. Each entry holds {excepttype, pc, inst}.
// Supports exception flush (kills everything) and taken-branch kill (keeps
// only the delay-slot head). Instructions carrying a fetch exception are
// stored as NOP (inst = 0).
// Optional feature: define INST_BUF_BYPASS_EN to forward an incoming
// instruction straight to ID in the same cycle when the queue is empty and
// ID is ready; the entry is then consumed without being written.
module id_inst_buffer #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         br_e,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [INST_W-1:0]            in_inst,
    input  logic [EXC_W-1:0]             in_exc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic [INST_W-1:0]            out_inst,
    output logic [EXC_W-1:0]             out_exc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [EXC_W-1:0]  exc_mem  [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count_nxt;

    logic has_data;
    logic bypass;
    logic push;
    logic pop;
    logic keep_head;

    // A fetch exception turns the instruction into a NOP so ID never decodes garbage.
    function automatic logic [INST_W-1:0] nop_force(input logic [INST_W-1:0] inst,
                                                    input logic [EXC_W-1:0]  exc);
        return (exc != '0) ? '0 : inst;
    endfunction

    assign has_data = (count != '0);
    // Acceptance depends only on occupancy, never on a same-cycle pop.
    assign in_ready = (count != FULL);

`ifdef INST_BUF_BYPASS_EN
    assign bypass = ~has_data & in_valid & out_ready & ~flush & ~br_e;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction is consumed directly by ID and never written.
    assign push      = in_valid & in_ready & ~flush & ~br_e & ~bypass;
    assign pop       = has_data & out_ready & ~flush;
    // Taken branch with ID stalled: the head is the delay slot and must survive.
    assign keep_head = br_e & ~flush & has_data & ~out_ready;

    // Next-state for pointers and occupancy; flush beats branch kill beats normal flow.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else if (br_e) begin
            if (keep_head) begin
                // Delay slot relocated to slot 0 so the queue restarts from a clean base.
                rd_ptr_nxt = '0;
                wr_ptr_nxt = AW'(1);
                count_nxt  = CW'(1);
            end else begin
                wr_ptr_nxt = '0;
                rd_ptr_nxt = '0;
                count_nxt  = '0;
            end
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + AW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Control state register; async active-low reset clears the queue instantly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Entry storage: write on push, or copy the kept delay slot down to slot 0.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= nop_force(in_inst, in_exc);
            exc_mem[wr_ptr]  <= in_exc;
        end else if (keep_head) begin
            pc_mem[0]   <= pc_mem[rd_ptr];
            inst_mem[0] <= inst_mem[rd_ptr];
            exc_mem[0]  <= exc_mem[rd_ptr];
        end
    end

    // Head presentation toward ID; fields read as zero whenever nothing is valid.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = '0;
        out_exc   = '0;
        if (has_data) begin
            out_valid = 1'b1;
            out_pc    = pc_mem[rd_ptr];
            out_inst  = inst_mem[rd_ptr];
            out_exc   = exc_mem[rd_ptr];
        end
`ifdef INST_BUF_BYPASS_EN
        else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = nop_force(in_inst, in_exc);
            out_exc   = in_exc;
        end
`endif
    end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Self-checking bench for id_inst_buffer: a queue-based reference model is
// checked against the DUT every cycle, plus directed literal expectations.
module tb_id_inst_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef INST_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          flush;
    logic          br_e;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst;
    logic [31:0]   in_exc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic [31:0]   out_exc;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    id_inst_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .br_e(br_e),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
    } ent_t;

    ent_t q[$];
    int   m_sz;
    bit   m_pop;
    bit   m_byp;
    ent_t m_h;

    always @(negedge rst) q.delete();

    always @(posedge clk) begin
        if (rst) begin
            m_sz  = q.size();
            m_pop = (m_sz > 0) && out_ready;
            m_byp = BYP && (m_sz == 0) && in_valid && out_ready && !flush && !br_e;
            if (flush) begin
                q.delete();
            end else if (br_e) begin
                if (m_pop || m_sz == 0) begin
                    q.delete();
                end else begin
                    m_h = q[0];
                    q.delete();
                    q.push_back(m_h);
                end
            end else begin
                if (m_pop) void'(q.pop_front());
                if (in_valid && m_sz < DEPTH && !m_byp)
                    q.push_back('{in_pc, (in_exc != 0) ? 32'h0 : in_inst, in_exc});
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    ent_t e_ent;
    bit   e_vld;
    always @(negedge clk) begin
        e_vld = 1'b0;
        e_ent = '0;
        if (q.size() > 0) begin
            e_vld = 1'b1;
            e_ent = q[0];
        end else if (BYP && rst && in_valid && out_ready && !flush && !br_e) begin
            e_vld = 1'b1;
            e_ent = '{in_pc, (in_exc != 0) ? 32'h0 : in_inst, in_exc};
        end
        chk("cmp_out_valid", 64'(out_valid), 64'(e_vld));
        chk("cmp_out_pc",    64'(out_pc),    64'(e_ent.pc));
        chk("cmp_out_inst",  64'(out_inst),  64'(e_ent.inst));
        chk("cmp_out_exc",   64'(out_exc),   64'(e_ent.exc));
        chk("cmp_in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
        chk("cmp_count",     64'(count),     64'(q.size()));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        in_exc   = exc;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; br_e = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_inst = '0; in_exc = '0; out_ready = 1'b1;
        step(); step();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        step();

        // Fill to full with ID stalled, reject a fifth, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'hBFC0_0000 + 32'(4 * i), 32'h2400_0000 + 32'(i), 32'h0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        push_one(32'hBFC0_0010, 32'h2400_0004, 32'h0);
        chk("fifth_rejected_count", 64'(count), 64'd4);
        chk("stall_head_pc", 64'(out_pc), 64'hBFC0_0000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc", 64'(out_pc), 64'(32'hBFC0_0000 + 32'(4 * i)));
            step();
        end
        chk("drain_count", 64'(count), 64'd0);

        // Full with a same-cycle pop still refuses the push.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h0000_0600 + 32'(4 * i), 32'h1111_0000 + 32'(i), 32'h0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h0000_0610; in_inst = 32'h1111_0004; in_exc = 32'h0;
        #1;
        chk("full_pop_in_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        chk("full_pop_count", 64'(count), 64'd3);
        step(); step(); step();
        chk("empty_again", 64'(count), 64'd0);

        // Streaming: push and pop every cycle across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_pc = 32'h0000_0200 + 32'(4 * i);
            in_inst = 32'h2222_0000 + 32'(i); in_exc = 32'h0;
            step();
            chk("stream_count", 64'(count), BYP ? 64'd0 : 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Branch kill with pop: head delivered, rest and new fetch dropped.
        out_ready = 1'b0;
        push_one(32'h100, 32'hA0, 32'h0);
        push_one(32'h104, 32'hA1, 32'h0);
        push_one(32'h108, 32'hA2, 32'h0);
        chk("br_pre_count", 64'(count), 64'd3);
        br_e = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h10C; in_inst = 32'hA3; in_exc = 32'h0;
        #1;
        chk("br_head_pc", 64'(out_pc), 64'h100);
        chk("br_head_valid", 64'(out_valid), 64'd1);
        step();
        br_e = 1'b0; in_valid = 1'b0;
        chk("br_post_count", 64'(count), 64'd0);
        chk("br_post_valid", 64'(out_valid), 64'd0);

        // Branch kill while stalled: delay slot kept alone.
        out_ready = 1'b0;
        push_one(32'h300, 32'hB0, 32'h0);
        push_one(32'h304, 32'hB1, 32'h0);
        br_e = 1'b1;
        step();
        br_e = 1'b0;
        chk("br_keep_count", 64'(count), 64'd1);
        chk("br_keep_pc", 64'(out_pc), 64'h300);
        push_one(32'h308, 32'hB2, 32'h0);
        chk("br_keep_append", 64'(count), 64'd2);
        out_ready = 1'b1;
        step(); step();

        // Flush with push and pop active.
        out_ready = 1'b0;
        push_one(32'h400, 32'hC0, 32'h0);
        push_one(32'h404, 32'hC1, 32'h0);
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h408; in_inst = 32'hC2; in_exc = 32'h0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        step();

        // Fetch exception stored as NOP.
        out_ready = 1'b0;
        push_one(32'h500, 32'h8C01_0000, 32'h0001_0000);
        chk("exc_inst", 64'(out_inst), 64'h0);
        chk("exc_exc", 64'(out_exc), 64'h0001_0000);
        chk("exc_pc", 64'(out_pc), 64'h500);
        out_ready = 1'b1;
        step();
        if (BYP) begin
            in_valid = 1'b1; in_pc = 32'h504; in_inst = 32'h8C01_0000; in_exc = 32'h0001_0000;
            #1;
            chk("byp_valid", 64'(out_valid), 64'd1);
            chk("byp_inst", 64'(out_inst), 64'h0);
            chk("byp_exc", 64'(out_exc), 64'h0001_0000);
            step();
            in_valid = 1'b0;
            chk("byp_count", 64'(count), 64'd0);
        end

        // Asynchronous reset mid-stream with three entries held.
        out_ready = 1'b0;
        push_one(32'h700, 32'hD0, 32'h0);
        push_one(32'h704, 32'hD1, 32'h0);
        push_one(32'h708, 32'hD2, 32'h0);
        chk("midrst_pre_count", 64'(count), 64'd3);
        rst = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_inst", 64'(out_inst), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        step(); step();
        rst = 1'b1; out_ready = 1'b1;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
